// File: rtl/tone_period_meter_if.sv
// Purpose: groups the tone input and the measurement results of
//          tone_period_meter into one bundle.
// Signals:
//   tone_in  square-wave tone, asynchronous to the meter clock
//   n_out    last measured half-period in clk cycles
//   n_valid  one-cycle pulse, n_out updated this cycle
//   locked   pitch stable
//   silent   no tone present
// Modports:
//   master  the meter: consumes tone_in, produces the results
//   slave   the user: drives tone_in, observes the results
interface tone_period_meter_if #(
  parameter int WIDTH = 32
);
  logic             tone_in;
  logic [WIDTH-1:0] n_out;
  logic             n_valid;
  logic             locked;
  logic             silent;

  modport master (
    input  tone_in,
    output n_out,
    output n_valid,
    output locked,
    output silent
  );

  modport slave (
    output tone_in,
    input  n_out,
    input  n_valid,
    input  locked,
    input  silent
  );
endinterface

// File: rtl/tone_period_meter.sv
// Purpose: measures the half-period of a square-wave tone in clk cycles,
//          recovering the divide factor N of a clk-driven toggle divider.
//          Flags lock once LOCK_CNT consecutive measurements agree within
//          TOL cycles, and silence when no edge arrives for TIMEOUT cycles.
// Ports:
//   clk    system clock
//   rst_n  synchronous reset, active HIGH despite the name
//   bus    tone_period_meter_if.master
//            tone_in (in), n_out/n_valid/locked/silent (out)
module tone_period_meter #(
  parameter int WIDTH    = 32,
  parameter int TIMEOUT  = 1000000,
  parameter int LOCK_CNT = 4,
  parameter int TOL      = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tone_period_meter_if.master  bus
);

  localparam int               MW       = $clog2(LOCK_CNT + 1);
  localparam logic [MW-1:0]    LOCK_MAX = MW'(LOCK_CNT);
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] TOL_W    = WIDTH'(TOL);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] n_out_r;
  logic             n_valid_r;
  logic             locked_r;
  logic             silent_r;
  logic [MW-1:0]    match_cnt;
  logic             first_meas;

  logic             tone_edge;
  logic [WIDTH-1:0] meas;
  logic             is_match;
  logic [MW-1:0]    next_match;

  // Distance between two unsigned measurements without wrap-around.
  function automatic logic [WIDTH-1:0] abs_diff(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Match counter saturates at LOCK_CNT so a long stable tone never wraps it.
  function automatic logic [MW-1:0] sat_inc(input logic [MW-1:0] m);
    return (m >= LOCK_MAX) ? LOCK_MAX : (m + 1'b1);
  endfunction

  // ---- stage: synchronized edge detect and measurement ----
  // Every edge sees the same s1->s2->s3 latency, so spacing is preserved.
  assign tone_edge  = s2 ^ s3;
  // cnt is cleared the cycle after an edge, so N-cycle spacing reads N-1.
  assign meas       = cnt + 1'b1;
  assign is_match   = (abs_diff(meas, n_out_r) <= TOL_W);
  assign next_match = sat_inc(match_cnt);

  // ---- stage: registered FSM and outputs ----
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= IDLE;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      cnt        <= '0;
      n_out_r    <= '0;
      n_valid_r  <= 1'b0;
      locked_r   <= 1'b0;
      silent_r   <= 1'b1;
      match_cnt  <= '0;
      first_meas <= 1'b0;
    end else begin
      s1        <= bus.tone_in;
      s2        <= s1;
      s3        <= s2;
      n_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (tone_edge) begin
            state      <= RUN;
            silent_r   <= 1'b0;
            match_cnt  <= '0;
            first_meas <= 1'b1;
          end
        end
        RUN: begin
          // An edge on the timeout cycle still wins: measure and stay.
          if (tone_edge) begin
            cnt       <= '0;
            n_out_r   <= meas;
            n_valid_r <= 1'b1;
            if (first_meas) begin
              first_meas <= 1'b0;
            end else if (is_match) begin
              match_cnt <= next_match;
              if (next_match == LOCK_MAX) begin
                locked_r <= 1'b1;
              end
            end else begin
              match_cnt <= '0;
              locked_r  <= 1'b0;
            end
          end else if (cnt == CNT_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            silent_r  <= 1'b1;
            locked_r  <= 1'b0;
            n_out_r   <= '0;
            match_cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.n_out   = n_out_r;
  assign bus.n_valid = n_valid_r;
  assign bus.locked  = locked_r;
  assign bus.silent  = silent_r;

endmodule

// File: tb/tb_tone_period_meter.sv
// Bench for tone_period_meter with TIMEOUT shortened to 64 cycles.
// The tone comes from a clk-synchronous toggle divider driven on the
// falling edge; a monitor logs every n_valid pulse and silent transition.
module tb_tone_period_meter;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  tone_period_meter_if #(.WIDTH(WIDTH)) bus ();

  tone_period_meter #(
    .WIDTH    (WIDTH),
    .TIMEOUT  (TIMEOUT),
    .LOCK_CNT (4),
    .TOL      (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int half;
    int exp_n;
    bit exp_locked;
  } vec_t;

  typedef struct {
    longint cyc;
    longint n;
    bit     locked;
    bit     silent;
  } pulse_t;

  vec_t   tbl [40];
  int     nv = 0;
  int     n_vec = 0;
  int     n_bad = 0;

  pulse_t pq [$];
  longint cyc = 0;
  bit     prev_silent = 1'b0;
  int     n_rises = 0;
  int     n_falls = 0;
  longint rise_cyc = 0;
  longint fall_cyc = 0;
  longint rise_n = 0;
  bit     rise_locked = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.n_valid)
      pq.push_back(pulse_t'{cyc, longint'(bus.n_out), bus.locked, bus.silent});
    prev_silent <= bus.silent;
    if (bus.silent && !prev_silent) begin
      n_rises     <= n_rises + 1;
      rise_cyc    <= cyc;
      rise_n      <= longint'(bus.n_out);
      rise_locked <= bus.locked;
    end
    if (!bus.silent && prev_silent) begin
      n_falls  <= n_falls + 1;
      fall_cyc <= cyc;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int h, input int n, input bit l);
    tbl[nv] = vec_t'{h, n, l};
    nv++;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_n_out"},   longint'(bus.n_out), 0);
    chk({tag, "_n_valid"}, bus.n_valid, 0);
    chk({tag, "_locked"},  bus.locked, 0);
    chk({tag, "_silent"},  bus.silent, 1);
  endtask

  // Plays table entries lo..hi as consecutive half-periods, optionally
  // preceded by the edge that wakes the meter from IDLE, then checks
  // every n_valid pulse against the table.
  task automatic run_seg(input int lo, input int hi, input bit from_idle);
    int base;
    int rises0;
    int falls0;
    int k;
    base   = pq.size();
    rises0 = n_rises;
    falls0 = n_falls;
    if (from_idle) bus.tone_in = ~bus.tone_in;
    for (int i = lo; i <= hi; i++) begin
      repeat (tbl[i].half) @(negedge clk);
      bus.tone_in = ~bus.tone_in;
    end
    repeat (6) @(negedge clk);
    chk($sformatf("seg%0d_pulse_count", lo), pq.size() - base, hi - lo + 1);
    chk($sformatf("seg%0d_no_timeout", lo), n_rises - rises0, 0);
    if (from_idle) begin
      chk($sformatf("seg%0d_silent_fall", lo), n_falls - falls0, 1);
      if (pq.size() > base)
        chk($sformatf("seg%0d_first_spacing", lo), pq[base].cyc - fall_cyc, tbl[lo].half);
    end
    for (int i = lo; i <= hi; i++) begin
      k = base + i - lo;
      if (k < pq.size()) begin
        chk($sformatf("v%0d_n_out", i),  pq[k].n, tbl[i].exp_n);
        chk($sformatf("v%0d_locked", i), pq[k].locked, tbl[i].exp_locked);
        chk($sformatf("v%0d_silent", i), pq[k].silent, 0);
        if (i > lo)
          chk($sformatf("v%0d_spacing", i), pq[k].cyc - pq[k-1].cyc, tbl[i].half);
      end
    end
  endtask

  initial begin
    int     bad;
    int     r0;
    int     q0;
    longint last;

    // Vectors: half-period, expected n_out and locked on the pulse it ends.
    for (int i = 0; i < 5; i++) add(5, 5, i == 4);     //  0-4  lock at N=5
    add(5, 5, 1'b1);                                   //  5
    for (int i = 0; i < 5; i++) add(8, 8, i == 4);     //  6-10 mismatch, relock at 8
    for (int i = 0; i < 5; i++) add(20, 20, i == 4);   // 11-15 lock at 20
    add(21, 21, 1'b1);                                 // 16    wobble within TOL
    add(22, 22, 1'b1);
    add(21, 21, 1'b1);
    add(20, 20, 1'b1);
    add(22, 22, 1'b1);                                 // 20    diff exactly TOL
    add(25, 25, 1'b0);                                 // 21    diff TOL+1 breaks lock
    for (int i = 0; i < 5; i++) add(10, 10, i == 4);   // 22-26 lock at 10
    for (int i = 0; i < 5; i++) add(7, 7, i == 4);     // 27-31 restart from IDLE at 7
    for (int i = 0; i < 5; i++) add(7, 7, i == 4);     // 32-36 relock after reset
    for (int i = 0; i < 3; i++) add(64, 64, 1'b0);     // 37-39 edge on cnt==63

    // Reset and a long idle stretch with no tone.
    bus.tone_in = 1'b0;
    rst_n       = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    chk_reset_values("reset");
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.silent !== 1'b1 || bus.locked !== 1'b0 ||
          bus.n_out !== '0 || bus.n_valid !== 1'b0)
        bad++;
    end
    chk("idle_outputs_bad_cycles", bad, 0);
    chk("idle_pulses", pq.size(), 0);

    // Lock at 5, switch to 8, wobble around 20, break, lock at 10.
    run_seg(0, 26, 1'b1);

    // Hold the tone: silence exactly TIMEOUT cycles after the last clear.
    last = (pq.size() > 0) ? pq[pq.size()-1].cyc : 0;
    r0   = n_rises;
    q0   = pq.size();
    repeat (80) @(negedge clk);
    chk("timeout_rise_count", n_rises - r0, 1);
    chk("timeout_delay", rise_cyc - last, TIMEOUT);
    chk("timeout_n_out", rise_n, 0);
    chk("timeout_locked", rise_locked, 0);
    chk("timeout_pulses", pq.size() - q0, 0);
    chk("timeout_silent_now", bus.silent, 1);

    // Restart from IDLE and lock at 7.
    run_seg(27, 31, 1'b1);
    chk("pre_reset_locked", bus.locked, 1);

    // One-cycle reset while locked, mid-measurement.
    q0    = pq.size();
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    chk_reset_values("midreset");
    repeat (10) @(negedge clk);
    chk("midreset_pulses", pq.size() - q0, 0);
    chk("midreset_silent_held", bus.silent, 1);

    // Relock at 7, then half-periods that land an edge on cnt==TIMEOUT-1.
    run_seg(32, 39, 1'b1);
    chk("final_silent", bus.silent, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
